// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl byte-serialising memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LenByte = 2'd0;
    localparam logic [1:0] LenHalf = 2'd1;
    localparam logic [1:0] LenWord = 2'd3;

    localparam int RamByteW = 8;

    localparam logic [31:0] IoMask   = 32'h0003_0000;
    localparam logic [31:0] IoValue  = 32'h0003_0000;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Length code to byte count; the unused code 2 behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LenByte: return 3'd1;
            LenHalf: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Registered priority grant between MEM and IF; the grant is held until the DONE cycle ends.
module mem_ctrl_arb (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic if_req,
    input  logic mem_req,
    input  logic idle,
    input  logic release_grant,
    output logic req_any,
    output logic sel_mem,
    output logic grant_if,
    output logic grant_mem
);

    logic grant_if_reg;
    logic grant_mem_reg;

    assign req_any   = if_req || mem_req;
    assign sel_mem   = mem_req;
    assign grant_if  = grant_if_reg;
    assign grant_mem = grant_mem_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_if_reg  <= 1'b0;
            grant_mem_reg <= 1'b0;
        end else if (rdy) begin
            if (idle && req_any) begin
                grant_mem_reg <= mem_req;
                grant_if_reg  <= !mem_req;
            end else if (release_grant) begin
                grant_mem_reg <= 1'b0;
                grant_if_reg  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM controller serving IF and MEM requesters.
// Optional write stall for the I/O region: define MEM_CTRL_IO_GUARD_EN.
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              busy,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    input  logic              io_buffer_full
);
    import mem_ctrl_pkg::*;

    localparam int Bytes = DATA_W / RamByteW;

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, len_reg, cnt_inc;
    logic [ADDR_W-1:0] addr_reg, ram_a_reg;
    logic [DATA_W-1:0] wdata_reg, result_reg;
    logic              we_reg, ram_wr_reg;
    logic [7:0]        ram_dout_reg;
    logic              req_any, sel_mem, grant_if, grant_mem;
    logic              start, stall, last, advance;
    logic [7:0]        wbyte [Bytes];

    mem_ctrl_arb u_arb (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .if_req        (if_req),
        .mem_req       (mem_req),
        .idle          (state_reg == IDLE),
        .release_grant (state_reg == DONE),
        .req_any       (req_any),
        .sel_mem       (sel_mem),
        .grant_if      (grant_if),
        .grant_mem     (grant_mem)
    );

    for (genvar gi = 0; gi < Bytes; gi++) begin : g_wbyte
        assign wbyte[gi] = wdata_reg[gi*RamByteW +: RamByteW];
    end

`ifdef MEM_CTRL_IO_GUARD_EN
    logic io_region;
    assign io_region = ((32'(addr_reg) & IoMask) == IoValue);
    assign stall     = (state_reg == BUSY) && we_reg && io_region && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign stall                 = 1'b0;
`endif

    assign start   = (state_reg == IDLE) && req_any;
    assign advance = (state_reg == BUSY) && !stall;
    assign cnt_inc = cnt_reg + 3'd1;
    // Reads need one extra cycle to capture the byte addressed last.
    assign last    = we_reg ? (cnt_reg == len_reg - 3'd1) : (cnt_reg == len_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else if (rdy) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_any) state_next = BUSY;
            BUSY:    if (!stall && last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        if_done  = 1'b0;
        mem_done = 1'b0;
        case (state_reg)
            BUSY: busy = 1'b1;
            DONE: begin
                busy     = 1'b1;
                if_done  = grant_if;
                mem_done = grant_mem;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            len_reg      <= '0;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            result_reg   <= DATA_W'(ZeroWord);
            ram_a_reg    <= '0;
            ram_wr_reg   <= 1'b0;
            ram_dout_reg <= '0;
        end else if (rdy) begin
            if (start) begin
                addr_reg     <= sel_mem ? mem_addr : if_addr;
                len_reg      <= sel_mem ? len_bytes(mem_len) : 3'd4;
                we_reg       <= sel_mem && mem_we;
                wdata_reg    <= sel_mem ? mem_wdata : '0;
                cnt_reg      <= '0;
                result_reg   <= DATA_W'(ZeroWord);
                ram_a_reg    <= sel_mem ? mem_addr : if_addr;
                ram_wr_reg   <= sel_mem && mem_we;
                ram_dout_reg <= (sel_mem && mem_we) ? mem_wdata[7:0] : 8'd0;
            end else if (advance) begin
                cnt_reg <= cnt_inc;
                if (!we_reg) begin
                    for (int i = 0; i < Bytes; i++) begin
                        if (cnt_reg == 3'(i + 1)) result_reg[i*RamByteW +: RamByteW] <= ram_din;
                    end
                end
                // Bus registers present the next byte; they return to zero once all bytes are issued.
                if (cnt_inc < len_reg) begin
                    ram_a_reg    <= addr_reg + ADDR_W'(cnt_inc);
                    ram_wr_reg   <= we_reg;
                    ram_dout_reg <= we_reg ? wbyte[cnt_inc[1:0]] : 8'd0;
                end else begin
                    ram_a_reg    <= '0;
                    ram_wr_reg   <= 1'b0;
                    ram_dout_reg <= '0;
                end
            end
        end
    end

    assign ram_a     = ram_a_reg;
    assign ram_dout  = ram_dout_reg;
    assign ram_wr    = ram_wr_reg && rdy && !stall;
    assign if_data   = if_done  ? result_reg : '0;
    assign mem_rdata = mem_done ? result_reg : '0;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter between instruction fetch (IF) and the MEM stage fed by the EX/MEM pipeline register. It shares the byte-wide synchronous RAM bus between the two requesters and serialises each 1/2/4-byte access into byte cycles. It returns assembled little-endian data with a one-cycle done pulse, and reports busy to the stall controller.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, requester data width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address (always word access)
- if_data  out  DATA_W  fetched word, valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1=store, 0=load
- mem_len  in  2  0=byte, 1=half, 3=word; code 2 is treated as word
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data, LSB first
- mem_rdata  out  DATA_W  load data, zero-extended, valid while mem_done=1
- mem_done  out  1  one-cycle completion pulse
- busy  out  1  high in BUSY and DONE
- ram_din  in  8  RAM read byte, valid one cycle after ram_a
- ram_dout  out  8  RAM write byte
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  1=write this cycle
- io_buffer_full  in  1  used only with MEM_CTRL_IO_GUARD_EN

## Operation
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE. All outputs are 0: if_data, mem_rdata, if_done, mem_done, busy, ram_a, ram_dout, ram_wr.
- IDLE to BUSY on any request. The grant, address, length (N=1/2/4), we and wdata are latched, and cnt=0.
- Arbitration: mem_req has priority over if_req. There is no preemption; a granted transfer always completes.
- BUSY, cnt<N: ram_a=base+cnt. On a write, ram_wr=1 and ram_dout=wdata byte cnt.
- BUSY read, cnt≥1: ram_din is stored into byte (cnt−1) of the result register.
- BUSY exit: a read leaves BUSY after cnt=N, giving N+1 cycles. A write leaves after cnt=N−1, giving N cycles.
- DONE: the granted requester's done=1 for exactly one cycle, with its data valid. Next state is IDLE.
- Requesters drop req on seeing done, so the request is low again in the following IDLE cycle.
- Address arithmetic is modulo 2^ADDR_W; base+cnt wraps at the top of memory.
- rdy=0: state, cnt, result and latches hold, and ram_wr is forced to 0. The RAM shares rdy, so a read in flight is not lost.
- rst during BUSY aborts the transfer. There is no done pulse, and any bytes already written stay written.

## Timing
- Req sampled high in IDLE at cycle 0:
  - word read: BUSY cycles 1–5, done at cycle 6
  - word write: BUSY cycles 1–4, done at cycle 5
  - byte read: done at cycle 3
  - byte write: done at cycle 2
- Throughput: the next transfer's request is sampled no earlier than the IDLE cycle after DONE.
- ram_a, ram_wr and ram_dout are registered outputs. In IDLE and DONE, ram_wr=0 and ram_a holds 0.

## Configuration
- MEM_CTRL_IO_GUARD_EN defined:
  - Applies to writes whose address has addr[17:16]=2'b11 (I/O region 0x30000).
  - While io_buffer_full=1, cnt does not advance and ram_wr=0.
  - A stall is inserted before each byte until io_buffer_full deasserts.
- Not defined: io_buffer_full is ignored and write timing is always N cycles.

## Structure
- Shared package holds:
  - state encodings
  - length codes (LenByte/LenHalf/LenWord)
  - IO region mask/value
  - ZeroWord and RAM byte width
- One sub-module, mem_ctrl_arb: a registered priority grant (MEM over IF) with a grant-hold-until-DONE rule.
- Byte sequencing and assembly live in mem_ctrl.

## Test plan
- IF word read at 0x100, RAM[0x100..0x103]=13,12,11,10 -> if_done at cycle 6, if_data=0x10111213, mem_done never high.
- if_req and mem_req rise together; MEM word store 0x12345678 to 0x200:
  - MEM first: ram_wr on cycles 1–4 at 0x200–0x203 with data 78,56,34,12, then mem_done at cycle 5.
  - IF served after: if_done at cycle 12.
- MEM half load at 0x301, RAM 0xAB,0xCD -> mem_rdata=0x0000CDAB at cycle 4.
- rdy low for 3 cycles mid word read -> same data; done delayed by exactly 3 cycles; no ram_wr pulses.
- rst asserted during cycle 2 of a word store -> next cycle is IDLE, all outputs 0, no done pulse, new if_req served normally.
- With MEM_CTRL_IO_GUARD_EN: byte store to 0x30000 while io_buffer_full=1 for 4 cycles -> ram_wr=0 during the hold, single write when it clears, mem_done the cycle after.
